// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register addressing, zero constants and enable levels
// used by the decode-stage register file and its scoreboard.
package cpu_pkg;

  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned RegNumDefault    = 32;
  localparam int unsigned RegAddrWidth     = $clog2(RegNumDefault);

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  localparam logic [DataWidthDefault-1:0] ZeroWord = '0;
  localparam reg_addr_t                   ZERO_REG = '0;

  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Write-pending scoreboard: one pending bit per register, set by issue, cleared
// by writeback, wiped by flush. Also qualifies read-port busy and issue readiness.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned RegNum    = RegNumDefault,
  parameter int unsigned NumRead   = 2,
  parameter int unsigned NumWrite  = 2,
  parameter int unsigned Bypass    = 1,
  parameter int unsigned AddrWidth = $clog2(RegNum)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NumWrite-1:0]                 we_i,
  input  logic [NumWrite-1:0][AddrWidth-1:0]  waddr_i,
  input  logic [NumRead-1:0]                  re_i,
  input  logic [NumRead-1:0][AddrWidth-1:0]   raddr_i,
  input  logic [NumRead-1:0]                  wr_match_i,
  input  logic                                issue_i,
  input  logic [AddrWidth-1:0]                issue_rd_i,
  input  logic                                flush_i,
  output logic                                issue_ready_o,
  output logic [NumRead-1:0]                  rbusy_o,
  output logic [RegNum-1:0]                   busy_o
);

  logic [RegNum-1:0] pend_q;
  logic [RegNum-1:0] pend_d;
  logic [RegNum-1:0] clr;

  always_comb begin
    clr = '0;
    for (int k = 0; k < NumWrite; k++) begin
      if (we_i[k] == WriteEnable) begin
        clr[waddr_i[k]] = 1'b1;
      end
    end
  end

  // A new producer issued in the same cycle as the old one retires keeps the bit set.
  always_comb begin
    pend_d = pend_q & ~clr;
    if (issue_i && (issue_rd_i != '0)) begin
      pend_d[issue_rd_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign busy_o        = pend_q;
  assign issue_ready_o = (issue_rd_i == '0) | ~pend_q[issue_rd_i] | clr[issue_rd_i];

  always_comb begin
    for (int j = 0; j < NumRead; j++) begin
      rbusy_o[j] = (re_i[j] == ReadEnable) && (raddr_i[j] != '0) && pend_q[raddr_i[j]]
                   && !((Bypass != 0) && wr_match_i[j]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage multi-port register file with write priority, optional same-cycle
// bypass and an integrated write-pending scoreboard for stall detection.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned DataWidth = DataWidthDefault,
  parameter int unsigned RegNum    = RegNumDefault,
  parameter int unsigned NumRead   = 2,
  parameter int unsigned NumWrite  = 2,
  parameter int unsigned Bypass    = 1,
  parameter int unsigned AddrWidth = $clog2(RegNum)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NumWrite-1:0]                 we_i,
  input  logic [NumWrite-1:0][AddrWidth-1:0]  waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumRead-1:0]                  re_i,
  input  logic [NumRead-1:0][AddrWidth-1:0]   raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumRead-1:0]                  rbusy_o,
  input  logic                                issue_i,
  input  logic [AddrWidth-1:0]                issue_rd_i,
  output logic                                issue_ready_o,
  input  logic                                flush_i,
  output logic [RegNum-1:0]                   busy_o
);

  logic [RegNum-1:0][DataWidth-1:0] mem_q;
  logic [RegNum-1:0][DataWidth-1:0] mem_d;
  logic [NumRead-1:0]               wr_match;

  // Ascending port order lets the highest-index writer overwrite earlier ones.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NumWrite; k++) begin
      if ((we_i[k] == WriteEnable) && (waddr_i[k] != '0)) begin
        mem_d[waddr_i[k]] = wdata_i[k];
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NumRead; j++) begin
      rdata_o[j]  = '0;
      wr_match[j] = 1'b0;
      if ((re_i[j] == ReadEnable) && (raddr_i[j] != '0)) begin
        rdata_o[j] = mem_q[raddr_i[j]];
        for (int k = 0; k < NumWrite; k++) begin
          if ((we_i[k] == WriteEnable) && (waddr_i[k] == raddr_i[j])) begin
            wr_match[j] = 1'b1;
            if (Bypass != 0) begin
              rdata_o[j] = wdata_i[k];
            end
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .RegNum    (RegNum),
    .NumRead   (NumRead),
    .NumWrite  (NumWrite),
    .Bypass    (Bypass),
    .AddrWidth (AddrWidth)
  ) u_scoreboard (
    .clk           (clk),
    .rstn          (rstn),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .re_i          (re_i),
    .raddr_i       (raddr_i),
    .wr_match_i    (wr_match),
    .issue_i       (issue_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .issue_ready_o (issue_ready_o),
    .rbusy_o       (rbusy_o),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: drives a bypassing and a non-bypassing instance in lockstep
// and compares both against an architectural register/pending-bit model.
module tb_regfile_sb;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        we, re;
  logic [1:0][4:0]   waddr, raddr;
  logic [1:0][31:0]  wdata;
  logic              issue, flush;
  logic [4:0]        issue_rd;

  logic [1:0][31:0]  rdata_b, rdata_n;
  logic [1:0]        rbusy_b, rbusy_n;
  logic              rdy_b, rdy_n;
  logic [31:0]       busy_b, busy_n;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  regfile_sb #(.Bypass(1)) dut_b (
    .clk(clk), .rstn(rstn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .issue_i(issue), .issue_rd_i(issue_rd), .issue_ready_o(rdy_b),
    .flush_i(flush), .busy_o(busy_b)
  );

  regfile_sb #(.Bypass(0)) dut_n (
    .clk(clk), .rstn(rstn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .issue_i(issue), .issue_rd_i(issue_rd), .issue_ready_o(rdy_n),
    .flush_i(flush), .busy_o(busy_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit write_hits(input logic [4:0] a);
    for (int k = 0; k < 2; k++) if (we[k] && waddr[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata(input int j, input bit byp);
    logic [31:0] v;
    if (raddr[j] == 5'd0 || !re[j]) return 32'h0;
    v = m_reg[raddr[j]];
    if (byp) for (int k = 0; k < 2; k++) if (we[k] && waddr[k] == raddr[j]) v = wdata[k];
    return v;
  endfunction

  function automatic logic exp_rbusy(input int j, input bit byp);
    return re[j] && raddr[j] != 5'd0 && m_pend[raddr[j]] && !(byp && write_hits(raddr[j]));
  endfunction

  function automatic logic exp_ready();
    return issue_rd == 5'd0 || !m_pend[issue_rd] || write_hits(issue_rd);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
    m_pend = 32'h0;
  endtask

  task automatic model_update();
    logic [31:0] np;
    for (int r = 1; r < 32; r++) begin
      if (flush)                           np[r] = 1'b0;
      else if (issue && issue_rd == 5'(r)) np[r] = 1'b1;
      else if (write_hits(5'(r)))          np[r] = 1'b0;
      else                                 np[r] = m_pend[r];
    end
    np[0] = 1'b0;
    for (int k = 0; k < 2; k++) if (we[k] && waddr[k] != 5'd0) m_reg[waddr[k]] = wdata[k];
    m_pend = np;
  endtask

  task automatic check_comb();
    for (int j = 0; j < 2; j++) begin
      chk("rdata_byp", rdata_b[j], exp_rdata(j, 1'b1));
      chk("rdata_nobyp", rdata_n[j], exp_rdata(j, 1'b0));
      chk("rbusy_byp", rbusy_b[j], exp_rbusy(j, 1'b1));
      chk("rbusy_nobyp", rbusy_n[j], exp_rbusy(j, 1'b0));
    end
    chk("ready_byp", rdy_b, exp_ready());
    chk("ready_nobyp", rdy_n, exp_ready());
  endtask

  task automatic idle();
    we = '0; re = '0; waddr = '0; raddr = '0; wdata = '0;
    issue = 1'b0; flush = 1'b0; issue_rd = '0;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic step();
    #2;
    check_comb();
    @(posedge clk);
    if (rstn) model_update();
    #1;
    chk("busy_byp", busy_b, m_pend);
    chk("busy_nobyp", busy_n, m_pend);
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    idle();
    rstn = 1'b0;
    re = 2'b11; raddr[0] = 5'd3; raddr[1] = 5'd4; issue_rd = 5'd3;
    #2;
    check_comb();
    chk("reset_busy", busy_b, 32'h0);
    chk("reset_ready", rdy_b, 1'b1);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    for (int r = 1; r < 32; r++) begin
      idle(); re = 2'b11; raddr[0] = 5'(r); raddr[1] = 5'(r);
      step();
    end

    // Write priority and bypass
    idle(); we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'h55;
    step();
    idle(); we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'h11; wdata[1] = 32'h22; re = 2'b01; raddr[0] = 5'd5;
    #1;
    chk("prio_bypass", rdata_b[0], 32'h22);
    chk("prio_nobypass_old", rdata_n[0], 32'h55);
    step();
    idle(); re = 2'b11; raddr[0] = 5'd5; raddr[1] = 5'd5;
    #1;
    chk("prio_stored_byp", rdata_b[1], 32'h22);
    chk("prio_stored_nobyp", rdata_n[1], 32'h22);
    step();

    // Register 0
    idle(); we[1] = 1'b1; waddr[1] = 5'd0; wdata[1] = 32'hFFFF_FFFF;
    issue = 1'b1; issue_rd = 5'd0; re = 2'b01; raddr[0] = 5'd0;
    #1;
    chk("r0_read_wcycle", rdata_b[0], 32'h0);
    step();
    idle(); re = 2'b01; raddr[0] = 5'd0;
    #1;
    chk("r0_read", rdata_b[0], 32'h0);
    chk("r0_busy", busy_b[0], 1'b0);
    step();

    // Scoreboard hazard
    idle(); issue = 1'b1; issue_rd = 5'd7;
    step();
    idle(); re = 2'b01; raddr[0] = 5'd7; issue_rd = 5'd7;
    #1;
    chk("haz_rbusy", rbusy_b[0], 1'b1);
    chk("haz_ready", rdy_b, 1'b0);
    step();
    idle(); re = 2'b01; raddr[0] = 5'd7; we[1] = 1'b1; waddr[1] = 5'd7; wdata[1] = 32'hABCD;
    issue_rd = 5'd7;
    #1;
    chk("wb_rbusy_byp", rbusy_b[0], 1'b0);
    chk("wb_rdata_byp", rdata_b[0], 32'hABCD);
    chk("wb_rbusy_nobyp", rbusy_n[0], 1'b1);
    chk("wb_ready", rdy_b, 1'b1);
    step();
    idle();
    #1;
    chk("wb_busy7", busy_b[7], 1'b0);
    step();

    // Simultaneous events
    idle(); issue = 1'b1; issue_rd = 5'd9; we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h99;
    step();
    idle();
    #1;
    chk("sim_busy9", busy_b[9], 1'b1);
    step();
    idle(); issue = 1'b1; issue_rd = 5'd9; flush = 1'b1;
    step();
    idle();
    #1;
    chk("flush_busy", busy_b, 32'h0);
    step();

    // Randomized traffic, addresses clustered to force collisions
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int k = 0; k < 2; k++) begin
        we[k]    = ($urandom_range(0, 2) != 0);
        waddr[k] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wdata[k] = $urandom;
        re[k]    = ($urandom_range(0, 3) != 0);
        raddr[k] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      issue    = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end

    // Asynchronous reset between clock edges
    idle(); we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd4; wdata[0] = 32'h333; wdata[1] = 32'h444;
    step();
    idle(); issue = 1'b1; issue_rd = 5'd3;
    step();
    idle(); issue = 1'b1; issue_rd = 5'd4;
    step();
    idle(); re = 2'b11; raddr[0] = 5'd3; raddr[1] = 5'd4; issue_rd = 5'd3;
    #1;
    chk("pre_rst_busy34", {busy_b[4], busy_b[3]}, 2'b11);
    chk("pre_rst_rdata3", rdata_b[0], 32'h333);
    rstn = 1'b0;
    #1;
    model_clear();
    check_comb();
    chk("arst_busy_byp", busy_b, 32'h0);
    chk("arst_busy_nobyp", busy_n, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
